// File: rtl/dec_scan_if.sv
// Command/status bundle between a scan controller and the decoder sequencer.
// The master issues sweep commands; the slave (the sequencer) drives the
// decoder select/enable and the sweep status flags.
interface dec_scan_if #(
    parameter int DWELL_W = 8
);
    logic               start;
    logic               stop;
    logic               mode;
    logic [DWELL_W-1:0] dwell;
    logic [3:0]         sel;
    logic               en;
    logic               busy;
    logic               wrap;
    logic               done;

    modport master (
        output start, stop, mode, dwell,
        input  sel, en, busy, wrap, done
    );

    modport slave (
        input  start, stop, mode, dwell,
        output sel, en, busy, wrap, done
    );
endinterface

// File: rtl/dec_scan_sequencer.sv
// Scan sequencer for a 4-to-16 active-low decoder. Walks the select code
// 0..15, holding each selection for dwell+1 enabled cycles, with an
// enable-low blanking gap ahead of every selection so two decoder outputs
// are never low together. Single-sweep or continuous operation.
module dec_scan_sequencer #(
    parameter int DWELL_W   = 8,
    parameter int BLANK_CYC = 1
) (
    input  logic       clk,
    input  logic       resetn,
    dec_scan_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Blank counter is kept at least one bit wide so the BLANK_CYC = 0
    // build still elaborates; in that build BLANK is never entered.
    localparam int            BW         = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
    localparam logic [BW-1:0] BLANK_LAST = (BLANK_CYC > 0) ? BW'(BLANK_CYC - 1) : '0;

    state_t             state_reg;
    logic [3:0]         sel_reg;
    logic               en_reg;
    logic               busy_reg;
    logic               wrap_reg;
    logic               done_reg;
    logic [DWELL_W-1:0] cnt_reg;
    logic [BW-1:0]      blank_reg;
    logic               mode_reg;
    logic [DWELL_W-1:0] dwell_reg;

    assign bus.sel  = sel_reg;
    assign bus.en   = en_reg;
    assign bus.busy = busy_reg;
    assign bus.wrap = wrap_reg;
    assign bus.done = done_reg;

    // Sweep FSM with registered outputs; the asynchronous reset pulls en low
    // immediately so no decoder output stays asserted through a reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg <= IDLE;
            sel_reg   <= 4'd0;
            en_reg    <= 1'b0;
            busy_reg  <= 1'b0;
            wrap_reg  <= 1'b0;
            done_reg  <= 1'b0;
            cnt_reg   <= '0;
            blank_reg <= '0;
            mode_reg  <= 1'b0;
            dwell_reg <= '0;
        end else begin
            wrap_reg <= 1'b0;
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    en_reg   <= 1'b0;
                    sel_reg  <= 4'd0;
                    busy_reg <= 1'b0;
                    if (bus.start && !bus.stop) begin
                        mode_reg  <= bus.mode;
                        dwell_reg <= bus.dwell;
                        busy_reg  <= 1'b1;
                        cnt_reg   <= '0;
                        blank_reg <= '0;
                        if (BLANK_CYC == 0) begin
                            state_reg <= HOLD;
                            en_reg    <= 1'b1;
                        end else begin
                            state_reg <= BLANK;
                        end
                    end
                end

                BLANK: begin
                    if (bus.stop) begin
                        state_reg <= IDLE;
                        en_reg    <= 1'b0;
                        sel_reg   <= 4'd0;
                        busy_reg  <= 1'b0;
                    end else if (blank_reg == BLANK_LAST) begin
                        state_reg <= HOLD;
                        en_reg    <= 1'b1;
                        cnt_reg   <= '0;
                    end else begin
                        blank_reg <= blank_reg + 1'b1;
                    end
                end

                HOLD: begin
                    if (bus.stop) begin
                        state_reg <= IDLE;
                        en_reg    <= 1'b0;
                        sel_reg   <= 4'd0;
                        busy_reg  <= 1'b0;
                    end else if (cnt_reg != dwell_reg) begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end else begin
                        // Hold complete: advance the index. The 4-bit add
                        // rolls 15 over to 0 for the next sweep.
                        cnt_reg   <= '0;
                        blank_reg <= '0;
                        sel_reg   <= sel_reg + 4'd1;
                        if (sel_reg == 4'd15) begin
                            wrap_reg <= 1'b1;
                        end
                        if (sel_reg == 4'd15 && !mode_reg) begin
                            state_reg <= IDLE;
                            en_reg    <= 1'b0;
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                        end else if (BLANK_CYC == 0) begin
                            state_reg <= HOLD;
                            en_reg    <= 1'b1;
                        end else begin
                            state_reg <= BLANK;
                            en_reg    <= 1'b0;
                        end
                    end
                end

                default: begin
                    state_reg <= IDLE;
                    en_reg    <= 1'b0;
                    sel_reg   <= 4'd0;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dec_scan_sequencer.sv
// Bench for dec_scan_sequencer. Stimulus pushes the expected decoder
// activity (every enabled cycle plus every wrap/done pulse, tagged with the
// clock edge it must follow) into a queue; a monitor pops and compares each
// time the DUT shows activity. A second instance built with BLANK_CYC = 0
// covers the gapless mode.
module tb_dec_scan_sequencer;

    typedef struct {
        int         cyc;
        logic [3:0] sel;
        logic       en;
        logic       wrap;
        logic       done;
        logic       busy;
    } ev_t;

    logic clk;
    logic resetn;
    int   cyc;
    int   n_checks;
    int   n_fail;
    ev_t  sb[$];

    dec_scan_if #(.DWELL_W(8)) bus ();
    dec_scan_if #(.DWELL_W(8)) bus0 ();

    dec_scan_sequencer #(.DWELL_W(8), .BLANK_CYC(1)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    dec_scan_sequencer #(.DWELL_W(8), .BLANK_CYC(0)) dut0 (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Monitor: every enabled cycle or status pulse must match the next
    // expected event; sel must not move while en stays high.
    initial begin
        ev_t        e;
        logic       prev_en;
        logic [3:0] prev_sel;
        prev_en  = 1'b0;
        prev_sel = 4'd0;
        forever begin
            @(negedge clk);
            if (bus.en || bus.wrap || bus.done) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_output: cyc=%0d sel=%0d en=%0b wrap=%0b done=%0b busy=%0b, required no activity",
                             cyc, bus.sel, bus.en, bus.wrap, bus.done, bus.busy);
                end else begin
                    e = sb.pop_front();
                    if (cyc !== e.cyc || bus.sel !== e.sel || bus.en !== e.en ||
                        bus.wrap !== e.wrap || bus.done !== e.done || bus.busy !== e.busy) begin
                        n_fail++;
                        $display("FAIL event: got cyc=%0d sel=%0d en=%0b wrap=%0b done=%0b busy=%0b, required cyc=%0d sel=%0d en=%0b wrap=%0b done=%0b busy=%0b",
                                 cyc, bus.sel, bus.en, bus.wrap, bus.done, bus.busy,
                                 e.cyc, e.sel, e.en, e.wrap, e.done, e.busy);
                    end
                end
            end
            if (prev_en && bus.en) begin
                n_checks++;
                if (bus.sel !== prev_sel) begin
                    n_fail++;
                    $display("FAIL sel_under_en: cyc=%0d sel changed %0d -> %0d while en stayed 1, required no change",
                             cyc, prev_sel, bus.sel);
                end
            end
            prev_en  = bus.en;
            prev_sel = bus.sel;
        end
    end

    task automatic push_ev(input int c, input logic [3:0] s, input logic e,
                           input logic w, input logic d, input logic b);
        ev_t x;
        x.cyc = c; x.sel = s; x.en = e; x.wrap = w; x.done = d; x.busy = b;
        sb.push_back(x);
    endtask

    // Expected activity for a BLANK_CYC = 1 sweep whose start is sampled at
    // edge k: index i, hold cycle j follows edge k + i*P + 1 + j with
    // P = dwell + 2; the wrap pulse follows edge k + 16*P of each sweep.
    task automatic push_sweeps(input int k, input int d, input int nsw,
                               input logic md, input int limit);
        int p;
        int c;
        p = d + 2;
        for (int sw = 0; sw < nsw; sw++) begin
            for (int i = 0; i < 16; i++) begin
                for (int j = 0; j <= d; j++) begin
                    c = k + (sw * 16 + i) * p + 1 + j;
                    if (c <= limit) push_ev(c, 4'(i), 1'b1, 1'b0, 1'b0, 1'b1);
                end
            end
            c = k + (sw + 1) * 16 * p;
            if (c <= limit) push_ev(c, 4'd0, 1'b0, 1'b1, !md, md);
        end
    endtask

    // Advance to just after the monitor's sample point of the next cycle.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string name, input int got, input int req);
        n_checks++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    task automatic check_sb_empty(input string name);
        check(name, sb.size(), 0);
    endtask

    initial begin
        int k;
        n_checks = 0;
        n_fail   = 0;
        resetn   = 1'b0;
        bus.start = 0; bus.stop = 0; bus.mode = 0; bus.dwell = 8'd0;
        bus0.start = 0; bus0.stop = 0; bus0.mode = 0; bus0.dwell = 8'd0;
        repeat (3) tick();

        // Reset state
        check("reset_sel",  int'(bus.sel), 0);
        check("reset_flags", int'({bus.en, bus.busy, bus.wrap, bus.done}), 0);
        resetn = 1'b1;
        repeat (2) tick();

        // Single sweep, dwell=2; start re-pulsed and dwell/mode changed at sel 5
        k = cyc + 1;
        push_sweeps(k, 2, 1, 1'b0, 1 << 30);
        bus.mode = 1'b0; bus.dwell = 8'd2; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("busy_after_start", int'(bus.busy), 1);
        check("en_in_blank", int'(bus.en), 0);
        while (cyc < k + 21) tick();
        check("sel_at_busy_start", int'(bus.sel), 5);
        bus.start = 1'b1; bus.dwell = 8'd9; bus.mode = 1'b1;
        tick();
        bus.start = 1'b0;
        while (cyc < k + 66) tick();
        check("single_busy_after_done", int'({bus.busy, bus.en}), 0);
        check_sb_empty("single_all_events");
        $display("single sweep dwell=2 finished at cyc %0d", cyc);

        // Start and stop together in IDLE
        bus.start = 1'b1; bus.stop = 1'b1;
        tick();
        bus.start = 1'b0; bus.stop = 1'b0;
        check("start_stop_busy", int'(bus.busy), 0);
        repeat (3) tick();
        check("start_stop_idle", int'({bus.busy, bus.en, bus.sel}), 0);
        $display("start+stop in idle done at cyc %0d", cyc);

        // Continuous, dwell=0: two full sweeps then stop
        k = cyc + 1;
        push_sweeps(k, 0, 2, 1'b1, 1 << 30);
        bus.mode = 1'b1; bus.dwell = 8'd0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        while (cyc < k + 64) tick();
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        check("cont_stop_flags", int'({bus.busy, bus.en, bus.wrap, bus.done}), 0);
        check("cont_stop_sel", int'(bus.sel), 0);
        repeat (3) tick();
        check_sb_empty("cont_all_events");
        $display("continuous dwell=0 stopped at cyc %0d", cyc);

        // Stop on the last cycle of the final hold, single mode, dwell=1
        k = cyc + 1;
        push_sweeps(k, 1, 1, 1'b0, k + 47);
        bus.mode = 1'b0; bus.dwell = 8'd1; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        while (cyc < k + 47) tick();
        check("final_hold_sel", int'({bus.sel, bus.en}), 31);
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        check("final_stop_flags", int'({bus.busy, bus.en, bus.wrap, bus.done}), 0);
        check("final_stop_sel", int'(bus.sel), 0);
        repeat (3) tick();
        check_sb_empty("final_stop_events");
        $display("stop in final hold done at cyc %0d", cyc);

        // Asynchronous reset mid-HOLD at sel 7
        k = cyc + 1;
        push_sweeps(k, 2, 1, 1'b0, k + 30);
        bus.mode = 1'b0; bus.dwell = 8'd2; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        while (cyc < k + 30) tick();
        check("pre_reset_sel_en", int'({bus.sel, bus.en}), 15);
        resetn = 1'b0;
        #1;
        check("async_reset_outputs", int'({bus.sel, bus.en, bus.busy}), 0);
        #1;
        resetn = 1'b1;
        repeat (5) tick();
        check("post_reset_idle", int'({bus.sel, bus.en, bus.busy}), 0);
        check_sb_empty("reset_events");
        $display("async reset mid-hold done at cyc %0d", cyc);

        // BLANK_CYC = 0 instance, dwell=0: en stays high, sel steps each cycle
        k = cyc + 1;
        bus0.mode = 1'b0; bus0.dwell = 8'd0; bus0.start = 1'b1;
        tick();
        bus0.start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("gapless_idx%0d", i),
                  int'({bus0.sel, bus0.en, bus0.busy, bus0.done}), (i << 3) | 6);
            tick();
        end
        check("gapless_done", int'({bus0.en, bus0.busy, bus0.wrap, bus0.done}), 3);
        check("gapless_cyc", cyc, k + 16);
        tick();
        check("gapless_idle", int'({bus0.en, bus0.busy, bus0.done}), 0);
        $display("gapless sweep done at cyc %0d", cyc);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
